// File: rtl/l2_arbiter.sv
// l2_arbiter
//   Shares the single unified L2 cache port between the L1 instruction cache
//   and the L1 data cache. One line-sized transaction is in flight at a time:
//   an I-side read or a D-side read/write is latched into registered L2
//   outputs, held until the L2 completes, and the completion is steered back
//   to the requester that owns the grant. Simultaneous requests are resolved
//   round-robin, and every grant made while both sides were requesting bumps a
//   saturating conflict counter for performance analysis.
//
// Ports
//   clk, reset            system clock; asynchronous active-high reset
//   icache_mem_*          I-side line read request / response
//   dcache_mem_*          D-side line read or write request / response
//   l2arb_mem_*           registered request to L2, L2 read data / completion
//   arb_conflicts         saturating count of grants made under contention
module l2_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic [ADDR_WIDTH-1:0] icache_mem_address,
  input  logic                  icache_mem_read,
  output logic [LINE_WIDTH-1:0] icache_mem_rdata,
  output logic                  icache_mem_resp,

  input  logic [ADDR_WIDTH-1:0] dcache_mem_address,
  input  logic                  dcache_mem_read,
  input  logic                  dcache_mem_write,
  input  logic [LINE_WIDTH-1:0] dcache_mem_wdata,
  output logic [LINE_WIDTH-1:0] dcache_mem_rdata,
  output logic                  dcache_mem_resp,

  output logic [ADDR_WIDTH-1:0] l2arb_mem_address,
  output logic                  l2arb_mem_read,
  output logic                  l2arb_mem_write,
  output logic [LINE_WIDTH-1:0] l2arb_mem_wdata,
  input  logic [LINE_WIDTH-1:0] l2arb_mem_rdata,
  input  logic                  l2arb_mem_resp,

  output logic [CNT_WIDTH-1:0]  arb_conflicts
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t state;

  // 1 when the most recent grant went to the D side. Resets to 1 so that the
  // I side wins the very first tie.
  logic last_grant_d;

  logic i_req;
  logic d_req;
  logic grant_i;
  logic grant_d;
  logic both_req;

  assign i_req    = icache_mem_read;
  assign d_req    = dcache_mem_read | dcache_mem_write;
  assign both_req = i_req & d_req;

  // On a tie the side that did not win last time gets the port, so a
  // requester that keeps holding its request waits at most one transaction.
  assign grant_i = i_req & (~d_req | last_grant_d);
  assign grant_d = d_req & (~i_req | ~last_grant_d);

  // Single state machine that also owns every registered L2-side output.
  // The L2 request is captured on the grant edge and then held untouched
  // until the L2 completes, so the L1 may change or drop its inputs freely
  // once granted. A D-side request with both read and write set is treated
  // as a write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      last_grant_d      <= 1'b1;
      l2arb_mem_address <= '0;
      l2arb_mem_read    <= 1'b0;
      l2arb_mem_write   <= 1'b0;
      l2arb_mem_wdata   <= '0;
      arb_conflicts     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i) begin
            state             <= SERVE_I;
            last_grant_d      <= 1'b0;
            l2arb_mem_address <= icache_mem_address;
            l2arb_mem_read    <= 1'b1;
            l2arb_mem_write   <= 1'b0;
          end else if (grant_d) begin
            state             <= SERVE_D;
            last_grant_d      <= 1'b1;
            l2arb_mem_address <= dcache_mem_address;
            l2arb_mem_read    <= dcache_mem_read & ~dcache_mem_write;
            l2arb_mem_write   <= dcache_mem_write;
            l2arb_mem_wdata   <= dcache_mem_wdata;
          end
          if (both_req && (arb_conflicts != '1)) begin
            arb_conflicts <= arb_conflicts + CNT_WIDTH'(1);
          end
        end

        SERVE_I, SERVE_D: begin
          if (l2arb_mem_resp) begin
            state           <= RELEASE;
            l2arb_mem_read  <= 1'b0;
            l2arb_mem_write <= 1'b0;
          end
        end

        // One dead cycle so the L1 that was just answered can drop its
        // request before the arbiter looks at requests again.
        RELEASE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Completion is passed through combinationally in the same cycle the L2
  // answers; a completion arriving outside a serve state reaches nobody.
  assign icache_mem_resp  = l2arb_mem_resp & (state == SERVE_I);
  assign dcache_mem_resp  = l2arb_mem_resp & (state == SERVE_D);
  assign icache_mem_rdata = l2arb_mem_rdata;
  assign dcache_mem_rdata = l2arb_mem_rdata;

endmodule
